alu_cmd_ctrl: RTL and testbench

ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

---
 rtl/alu_cmd_ctrl.sv | 153 +++++++++++++++
 tb/tb_alu_cmd_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_ctrl.sv
// Command FIFO feeding a registered operand stage for an external combinational ALU,
// with a result-hold handshake, divide-by-zero override and a completed-result counter.
module alu_cmd_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [3:0] cmd_sel,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [7:0] alu_out,
  input  logic       alu_carry,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_carry,
  output logic       res_dz,
  output logic [3:0] res_sel,
  output logic [7:0] res_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [3:0] SEL_DIV = 4'b0011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          r_state;
  logic [19:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  logic [7:0]      r_alu_a;
  logic [7:0]      r_alu_b;
  logic [3:0]      r_alu_sel;
  logic            r_res_valid;
  logic [7:0]      r_res_data;
  logic            r_res_carry;
  logic            r_res_dz;
  logic [3:0]      r_res_sel;
  logic [7:0]      r_res_cnt;

  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_dz;
  logic [19:0]     w_head;

  // cmd_ready depends only on the registered occupancy, never on res_ready/cmd_valid
  assign w_empty   = (r_count == '0);
  assign cmd_ready = (r_count < CW'(DEPTH));
  assign w_push    = cmd_valid && cmd_ready;
  assign w_pop     = !w_empty && ((r_state == IDLE) || ((r_state == HOLD) && res_ready));
  assign w_head    = r_mem[r_rptr];
  assign w_dz      = (r_alu_sel == SEL_DIV) && (r_alu_b == 8'd0);

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_carry = r_res_carry;
  assign res_dz    = r_res_dz;
  assign res_sel   = r_res_sel;
  assign res_cnt   = r_res_cnt;

  // FIFO storage carries data only, so it needs no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {cmd_a, cmd_b, cmd_sel};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_carry <= 1'b0;
      r_res_dz    <= 1'b0;
      r_res_sel   <= '0;
      r_res_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_alu_a   <= w_head[19:12];
            r_alu_b   <= w_head[11:4];
            r_alu_sel <= w_head[3:0];
            r_state   <= EXEC;
          end
        end
        EXEC: begin
          r_res_data  <= w_dz ? 8'hFF : alu_out;
          r_res_carry <= alu_carry;
          r_res_dz    <= w_dz;
          r_res_sel   <= r_alu_sel;
          r_res_valid <= 1'b1;
          r_state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_res_cnt   <= r_res_cnt + 1'b1;
            if (w_pop) begin
              r_alu_a   <= w_head[19:12];
              r_alu_b   <= w_head[11:4];
              r_alu_sel <= w_head[3:0];
              r_state   <= EXEC;
            end else begin
              r_state   <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Randomized bench for alu_cmd_ctrl: a queue-based reference model predicts every result,
// plus directed latency, backpressure, throughput, reset and counter-wrap scenarios.
module tb_alu_cmd_ctrl;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [3:0] cmd_sel;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_carry;
  logic       res_dz;
  logic [3:0] res_sel;
  logic [7:0] res_cnt;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
  } cmd_t;

  cmd_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_cnt = 8'd0;
  longint      cyc = 0;
  longint      last_hs = -1;
  bit          tput_mode = 1'b0;
  bit          rnd_mode = 1'b0;
  bit          hold_prev = 1'b0;
  logic [14:0] snap = '0;

  always #5 clk = ~clk;

  alu_cmd_ctrl #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_sel   (cmd_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_carry (res_carry),
    .res_dz    (res_dz),
    .res_sel   (res_sel),
    .res_cnt   (res_cnt)
  );

  // Downstream ALU: {carry, result}; divide by zero deliberately returns 0 here
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] sel);
    logic [8:0] r;
    case (sel)
      4'b0000: r = {1'b0, a} + {1'b0, b};
      4'b0001: r = {1'b0, a} - {1'b0, b};
      4'b0010: r = {1'b0, a & b};
      4'b0011: r = (b == 8'd0) ? 9'h000 : {1'b0, a / b};
      default: r = {1'b0, a ^ b};
    endcase
    return r;
  endfunction

  assign {alu_carry, alu_out} = alu_fn(alu_a, alu_b, alu_sel);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Mid-cycle sample: handshakes and pushes seen here complete at the next rising edge
  task automatic monitor_step();
    cmd_t       c;
    logic [8:0] r;
    logic       dz;
    if (!rst_n) begin
      q.delete();
      exp_cnt   = 8'd0;
      hold_prev = 1'b0;
      last_hs   = -1;
    end else begin
      if (hold_prev) begin
        check("hold_valid", res_valid, 1);
        check("hold_stable", {res_sel, res_dz, res_carry, res_data}, snap);
      end
      if (res_valid && res_ready) begin
        check("result_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          c  = q.pop_front();
          r  = alu_fn(c.a, c.b, c.sel);
          dz = (c.sel == 4'b0011) && (c.b == 8'd0);
          check("res_data", res_data, dz ? 8'hFF : r[7:0]);
          check("res_carry", res_carry, r[8]);
          check("res_dz", res_dz, dz);
          check("res_sel", res_sel, c.sel);
          check("res_cnt", res_cnt, exp_cnt);
          exp_cnt = exp_cnt + 8'd1;
          if (tput_mode) begin
            if (last_hs >= 0) check("tput_gap", 32'(cyc - last_hs), 2);
            last_hs = cyc;
          end
        end
      end
      hold_prev = res_valid && !res_ready;
      snap      = {res_sel, res_dz, res_carry, res_data};
      if (cmd_valid && cmd_ready) q.push_back('{a: cmd_a, b: cmd_b, sel: cmd_sel});
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor_step();
    @(posedge clk);
    #1;
    cyc++;
    if (rnd_mode) res_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    int   n = 0;
    logic acc;
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_sel   = sel;
    do begin
      acc = cmd_ready;
      tick();
      n++;
    end while (!acc && n < 1000);
    check("push_accepted", acc, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rnd_mode  = 1'b0;
    res_ready = 1'b1;
    while ((q.size() != 0 || res_valid) && n < 400) begin
      tick();
      n++;
    end
    check("drain_done", q.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_res"}, {res_valid, res_data, res_carry, res_dz, res_sel}, 0);
    check({tag, "_alu"}, {alu_a, alu_b, alu_sel}, 0);
    check({tag, "_cnt"}, res_cnt, 0);
    check({tag, "_ready"}, cmd_ready, 1);
  endtask

  task automatic latency_case(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input logic [3:0] sel, input logic [7:0] ed,
                              input logic ec, input logic edz);
    res_ready = 1'b1;
    push_cmd(a, b, sel);
    check({tag, "_lat0"}, res_valid, 0);
    tick();
    check({tag, "_lat1"}, res_valid, 0);
    tick();
    check({tag, "_lat2"}, res_valid, 1);
    check({tag, "_data"}, res_data, ed);
    check({tag, "_carry"}, res_carry, ec);
    check({tag, "_dz"}, res_dz, edz);
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t reached, checks %0d errors %0d", $time, checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_sel   = '0;
    res_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_reset_values("post_reset");

    // Add, divide-by-zero override, ordinary divide
    latency_case("add", 8'd200, 8'd100, 4'b0000, 8'd44, 1'b1, 1'b0);
    tick();
    check("add_cnt", res_cnt, 1);
    check("alu_hold", {alu_a, alu_b, alu_sel}, {8'd200, 8'd100, 4'b0000});
    latency_case("div0", 8'd9, 8'd0, 4'b0011, 8'hFF, 1'b0, 1'b1);
    latency_case("div", 8'd9, 8'd3, 4'b0011, 8'd3, 1'b0, 1'b0);

    // Backpressure: one result held plus a full FIFO
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(8'($urandom), 8'($urandom), 4'($urandom));
    check("bp_full", cmd_ready, 0);
    check("bp_valid", res_valid, 1);
    cmd_valid = 1'b1;
    cmd_a     = 8'hAA;
    cmd_b     = 8'h55;
    cmd_sel   = 4'b0001;
    for (int i = 0; i < 4; i++) tick();
    cmd_valid = 1'b0;
    check("bp_still_full", cmd_ready, 0);
    drain();
    check("bp_empty_ready", cmd_ready, 1);

    // Throughput with res_ready held high
    res_ready = 1'b1;
    tput_mode = 1'b1;
    last_hs   = -1;
    for (int i = 0; i < 8; i++) push_cmd(8'($urandom), 8'($urandom), 4'($urandom_range(0, 3)));
    drain();
    tput_mode = 1'b0;
    check("tput_cnt", res_cnt, exp_cnt);

    // Reset while a command is executing and more are queued
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(8'($urandom), 8'($urandom), 4'($urandom));
    res_ready = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_values("midop_reset");
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("post_rst_valid", res_valid, 0);
    check("post_rst_cnt", res_cnt, 0);

    // Random traffic, then top up to exactly 256 completed handshakes since reset
    rnd_mode = 1'b1;
    for (int i = 0; i < 250; i++) begin
      push_cmd(8'($urandom), ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom),
               4'($urandom));
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end
    drain();
    check("rnd_cnt", res_cnt, 250);
    for (int i = 0; i < 6; i++) push_cmd(8'($urandom), 8'($urandom), 4'($urandom));
    drain();
    tick();
    check("cnt_wrap", res_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
